// File: rtl/frame_pack_fifo_if.sv
// frame_pack_fifo_if: pixel write stream in, packed-word show-ahead FIFO read port out; slave=packer side, master=source/sink side
interface frame_pack_fifo_if #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int DEPTH_WIDTH    = 4
);
  logic                      in_en;
  logic [IN_DATA_WIDTH-1:0]  in_data;
  logic                      in_last;
  logic                      in_rdy;
  logic                      out_en;
  logic                      out_vld;
  logic [OUT_DATA_WIDTH-1:0] out_data;
  logic                      out_last;
  logic [DEPTH_WIDTH:0]      level;
  modport slave (
    input  in_en, in_data, in_last, out_en,
    output in_rdy, out_vld, out_data, out_last, level
  );
  modport master (
    output in_en, in_data, in_last, out_en,
    input  in_rdy, out_vld, out_data, out_last, level
  );
endinterface

// File: rtl/frame_pack_fifo.sv
// frame_pack_fifo: packs 16-bit pixels 8-per-word into a 16-deep show-ahead FIFO; ports clk, rst, bus (in_en/in_data/in_last/in_rdy, out_en/out_vld/out_data/out_last, level)
module frame_pack_fifo #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int DEPTH_WIDTH    = 4
) (
  input logic             clk,
  input logic             rst,
  frame_pack_fifo_if.slave bus
);
  localparam int RATIO = OUT_DATA_WIDTH / IN_DATA_WIDTH;
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
  localparam logic [DEPTH_WIDTH:0] FULL = (DEPTH_WIDTH + 1)'(DEPTH);
  logic [LW-1:0]             lane_q, lane_d;
  logic [OUT_DATA_WIDTH-1:0] acc_q, acc_d, word;
  logic [DEPTH_WIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]      level_q, level_d;
  logic [OUT_DATA_WIDTH:0]   mem_q [DEPTH];
  logic                      accept, commit, pop;
  always_comb begin
    bus.in_rdy = !rst && (level_q != FULL);
    bus.out_vld = level_q != '0;
    bus.out_data = bus.out_vld ? mem_q[rd_ptr_q][OUT_DATA_WIDTH-1:0] : '0;
    bus.out_last = bus.out_vld ? mem_q[rd_ptr_q][OUT_DATA_WIDTH] : 1'b0;
    bus.level = level_q;
    accept = bus.in_en && bus.in_rdy;
    commit = accept && (lane_q == LAST_LANE || bus.in_last);
    pop = bus.out_en && bus.out_vld;
    word = acc_q;
    for (int i = 0; i < RATIO; i++)
      if (LW'(i) == lane_q) word[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = bus.in_data;
    acc_d = commit ? '0 : accept ? word : acc_q;
    lane_d = commit ? '0 : accept ? lane_q + LW'(1) : lane_q;
    wr_ptr_d = commit ? wr_ptr_q + DEPTH_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_WIDTH'(1) : rd_ptr_q;
    level_d = (commit && !pop) ? level_q + (DEPTH_WIDTH + 1)'(1) :
              (pop && !commit) ? level_q - (DEPTH_WIDTH + 1)'(1) : level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      acc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
    if (commit) mem_q[wr_ptr_q] <= {bus.in_last, word};
  end
endmodule

// File: tb/tb_frame_pack_fifo.sv
// tb_frame_pack_fifo: directed self-checking bench for frame_pack_fifo
module tb_frame_pack_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  frame_pack_fifo_if bus ();
  frame_pack_fifo dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] mkword(input int base);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(base + j);
    return w;
  endfunction
  task automatic push(input logic [15:0] d, input logic l);
    bus.in_en = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    for (int t = 0; t < 50 && !bus.in_rdy; t++) step();
    if (!bus.in_rdy) chk("rdy_timeout", 128'(bus.in_rdy), 128'd1);
    step();
    bus.in_en = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [127:0] exp);
    chk(tag, bus.out_data, exp);
    bus.out_en = 1'b1;
    step();
    bus.out_en = 1'b0;
  endtask
  logic [127:0] sb[$];
  int n;
  initial begin
    bus.in_en = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_en = 1'b0;
    // 1: reset state and one full word
    step();
    step();
    chk("rst_vld", 128'(bus.out_vld), 128'd0);
    chk("rst_level", 128'(bus.level), 128'd0);
    chk("rst_data", bus.out_data, 128'd0);
    chk("rst_last", 128'(bus.out_last), 128'd0);
    chk("rst_rdy", 128'(bus.in_rdy), 128'd0);
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 128'(bus.in_rdy), 128'd1);
    for (int i = 1; i <= 7; i++) push(16'(i), 1'b0);
    chk("t1_vld_early", 128'(bus.out_vld), 128'd0);
    push(16'd8, 1'b0);
    chk("t1_vld", 128'(bus.out_vld), 128'd1);
    chk("t1_data", bus.out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_last", 128'(bus.out_last), 128'd0);
    chk("t1_level", 128'(bus.level), 128'd1);
    pop_chk("t1_pop", 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_level0", 128'(bus.level), 128'd0);
    chk("t1_vld0", 128'(bus.out_vld), 128'd0);
    // 2: partial frame flush, next frame restarts at lane 0, last on lane 7
    push(16'h00A1, 1'b0);
    push(16'h00A2, 1'b0);
    push(16'h00A3, 1'b1);
    chk("t2_data", bus.out_data, 128'h00A3_00A2_00A1);
    chk("t2_last", 128'(bus.out_last), 128'd1);
    pop_chk("t2_pop", 128'h00A3_00A2_00A1);
    push(16'h00B1, 1'b1);
    chk("t2_lane0", bus.out_data, 128'h00B1);
    pop_chk("t2_pop2", 128'h00B1);
    for (int i = 0; i < 8; i++) push(16'(16'h0C0 + i), i == 7);
    chk("t2_full_last", 128'(bus.out_last), 128'd1);
    chk("t2_full_level", 128'(bus.level), 128'd1);
    pop_chk("t2_full_data", mkword(16'h0C0));
    chk("t2_full_level0", 128'(bus.level), 128'd0);
    // 3: fill to 16 words, hold pixel 128 until one pop
    for (int i = 0; i < 128; i++) push(16'(i), 1'b0);
    chk("t3_level16", 128'(bus.level), 128'd16);
    chk("t3_rdy0", 128'(bus.in_rdy), 128'd0);
    bus.in_en = 1'b1;
    bus.in_data = 16'd128;
    for (int t = 0; t < 3; t++) step();
    chk("t3_hold_level", 128'(bus.level), 128'd16);
    chk("t3_head", bus.out_data, mkword(0));
    bus.out_en = 1'b1;
    step();
    bus.out_en = 1'b0;
    chk("t3_no_pushthru", 128'(bus.level), 128'd15);
    chk("t3_rdy1", 128'(bus.in_rdy), 128'd1);
    step();
    bus.in_en = 1'b0;
    chk("t3_accepted", 128'(bus.level), 128'd15);
    for (int i = 129; i < 136; i++) push(16'(i), 1'b0);
    chk("t3_refull", 128'(bus.level), 128'd16);
    for (int k = 1; k < 17; k++) pop_chk("t3_drain", mkword(8 * k));
    chk("t3_empty", 128'(bus.level), 128'd0);
    // 4: continuous stream with out_en held high
    bus.out_en = 1'b1;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      bus.in_en = 1'b1;
      bus.in_data = 16'(16'h300 + i);
      chk("t4_rdy", 128'(bus.in_rdy), 128'd1);
      step();
      chk("t4_level_le1", 128'(bus.level <= 1), 128'd1);
      if (bus.out_vld) begin
        chk("t4_data", bus.out_data, mkword(16'h300 + 8 * n));
        n++;
      end
    end
    chk("t4_words", 128'(n), 128'd4);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 16'(16'h400 + i);
      bus.in_last = 1'b1;
      step();
      chk("t4_simul_level", 128'(bus.level), 128'd1);
      chk("t4_simul_data", bus.out_data, 128'(16'h400 + i));
    end
    bus.in_en = 1'b0;
    bus.in_last = 1'b0;
    step();
    bus.out_en = 1'b0;
    chk("t4_drained", 128'(bus.level), 128'd0);
    // 5: reset mid-frame with buffered words
    for (int i = 0; i < 21; i++) push(16'(16'h500 + i), 1'b0);
    chk("t5_pre_level", 128'(bus.level), 128'd2);
    rst = 1'b1;
    step();
    chk("t5_vld", 128'(bus.out_vld), 128'd0);
    chk("t5_level", 128'(bus.level), 128'd0);
    chk("t5_data", bus.out_data, 128'd0);
    chk("t5_rdy", 128'(bus.in_rdy), 128'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) push(16'(16'h50 + i), 1'b0);
    chk("t5_level1", 128'(bus.level), 128'd1);
    pop_chk("t5_clean", mkword(16'h50));
    // 6: pops on empty are ignored, then pointer wrap
    bus.out_en = 1'b1;
    for (int t = 0; t < 3; t++) step();
    bus.out_en = 1'b0;
    chk("t6_empty_level", 128'(bus.level), 128'd0);
    chk("t6_empty_vld", 128'(bus.out_vld), 128'd0);
    for (int i = 0; i < 8; i++) push(16'(16'h600 + i), 1'b0);
    pop_chk("t6_after_empty_pop", mkword(16'h600));
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 10; w++) begin
        for (int j = 0; j < 8; j++) push(16'(16'h1000 + 8 * (10 * r + w) + j), 1'b0);
        sb.push_back(mkword(16'h1000 + 8 * (10 * r + w)));
      end
      while (sb.size() > 0) pop_chk("t6_wrap", sb.pop_front());
    end
    chk("t6_final_level", 128'(bus.level), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
